// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM status and the RAM-port arbiter state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Registered arbiter sharing the single RAM port between instruction fetch and
// data access; data has priority, a saturating counter bounds fetch starvation.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   arb_state_t state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       dreq, force_i;

   assign dreq    = dREN | dWEN;
   assign force_i = (starve_q == SMAX) && iREN;
   assign iload   = ramload;
   assign dload   = ramload;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      unique case (state_q)
         IDLE: begin
            if (dreq && !force_i)
               state_d = DGRANT;
            else if (iREN)
               state_d = IGRANT;
            if (!iREN)
               starve_d = 4'd0;
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            // A withdrawn request abandons the grant without releasing dwait.
            if (!dreq) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               dwait   = 1'b0;
               state_d = IDLE;
               if (iREN && starve_q < SMAX)
                  starve_d = starve_q + 4'd1;
            end
         end
         IGRANT: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            if (!iREN) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               iwait    = 1'b0;
               state_d  = IDLE;
               starve_d = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   localparam int SMAX = 4;

   logic      CLK, RST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN;
   word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
   ramstate_t ramstate;

   memory_arbiter #(.STARVE_MAX(SMAX)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait),
      .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: who currently owns the port ("none", "fetch", "data") and how many
   // data transactions finished in a row while a fetch was waiting.
   string owner = "none";
   int    streak = 0;
   int    d_before_i = 0;
   bit    i_seen = 0;

   task automatic step(input bit rst, input bit ir, input bit dr, input bit dw,
                       input int rs, input word_t ia, input word_t da,
                       input word_t ds, input word_t rl);
      bit    want_d, done;
      bit    e_ren, e_wen, e_iw, e_dw;
      word_t e_addr, e_store;
      RST = rst; iREN = ir; dREN = dr; dWEN = dw;
      ramstate = ramstate_t'(rs[1:0]);
      iaddr = ia; daddr = da; dstore = ds; ramload = rl;
      if (rst) begin owner = "none"; streak = 0; end
      #4;
      want_d = dr || dw;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iw = 1; e_dw = 1; done = 0;
      if (owner == "data") begin
         e_addr = da; e_store = ds; e_wen = dw; e_ren = dr && !dw;
         done = want_d && rs == 2;
         e_dw = !done;
      end else if (owner == "fetch") begin
         e_addr = ia; e_ren = 1;
         done = ir && rs == 2;
         e_iw = !done;
      end
      chk("iwait", 32'(iwait), 32'(e_iw));
      chk("dwait", 32'(dwait), 32'(e_dw));
      chk("ramREN", 32'(ramREN), 32'(e_ren));
      chk("ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_store);
      chk("iload", iload, rl);
      chk("dload", dload, rl);
      if (!dwait && !i_seen) d_before_i++;
      if (!iwait) i_seen = 1;
      if (!rst) begin
         if (owner == "none") begin
            if (want_d && !(streak == SMAX && ir)) owner = "data";
            else if (ir) owner = "fetch";
            if (!ir) streak = 0;
         end else if (owner == "data") begin
            if (!want_d) owner = "none";
            else if (done) begin
               owner = "none";
               if (ir) streak = (streak + 1 > SMAX) ? SMAX : streak + 1;
            end
         end else begin
            if (!ir) owner = "none";
            else if (done) begin owner = "none"; streak = 0; end
         end
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      RST = 1; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
      @(posedge CLK); #1;
      // reset with both requests high, then first edge grants data
      step(1, 1, 1, 0, 2, 32'h10, 32'h20, 32'h0, 32'h1);
      step(1, 1, 1, 0, 2, 32'h10, 32'h20, 32'h0, 32'h2);
      step(0, 1, 1, 0, 1, 32'h10, 32'h20, 32'h0, 32'h3);
      step(0, 1, 1, 0, 1, 32'h10, 32'h20, 32'h0, 32'h4);
      chk("first_grant_data", 32'(ramaddr), 32'h20);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // fetch only: 3 BUSY then ACCESS
      step(0, 1, 0, 0, 0, 32'h40, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 1, 32'h40, 0, 0, 32'h55);
      step(0, 1, 0, 0, 2, 32'h40, 0, 0, 32'h1234);
      step(0, 0, 0, 0, 2, 32'h40, 0, 0, 0);
      // data write
      step(0, 0, 0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 0);
      step(0, 0, 1, 1, 1, 0, 32'h100, 32'hDEADBEEF, 0);
      step(0, 0, 0, 1, 2, 0, 32'h100, 32'hDEADBEEF, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // starvation: fetch held, data back-to-back, RAM always ACCESS
      d_before_i = 0; i_seen = 0;
      for (int k = 0; k < 14; k++) step(0, 1, 1, 0, 2, 32'h80, 32'h200 + k, 0, k);
      chk("starve_data_before_fetch", 32'(d_before_i), 32'(SMAX));
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // ERROR twice then ACCESS
      step(0, 0, 1, 0, 0, 0, 32'h300, 0, 0);
      step(0, 0, 1, 0, 3, 0, 32'h300, 0, 0);
      step(0, 0, 1, 0, 3, 0, 32'h300, 0, 0);
      step(0, 0, 1, 0, 2, 0, 32'h300, 0, 32'h77);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // reset pulse mid-grant, then request withdrawn mid-grant
      step(0, 0, 1, 0, 1, 0, 32'h400, 0, 0);
      step(0, 0, 1, 0, 1, 0, 32'h400, 0, 0);
      step(1, 0, 1, 0, 2, 0, 32'h400, 0, 0);
      step(0, 0, 1, 0, 1, 0, 32'h404, 0, 0);
      step(0, 0, 0, 0, 2, 0, 32'h404, 0, 0);
      step(0, 0, 0, 0, 2, 0, 0, 0, 0);
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         bit r, ir, dr, dw;
         int rs;
         r  = ($urandom_range(0, 199) == 0);
         ir = ($urandom_range(0, 9) < 7);
         dr = ($urandom_range(0, 9) < 5);
         dw = ($urandom_range(0, 9) < 3);
         rs = $urandom_range(0, 3);
         step(r, ir, dr, dw, rs, $urandom, $urandom, $urandom, $urandom);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Registered arbiter sharing the single RAM port between the instruction-fetch and data-access requesters of the single-cycle core. It sits between the datapath's request/wait signals and the RAM model. It latches one requester per RAM transaction and holds that grant until RAM reports ACCESS. Data accesses have priority, and a saturating counter prevents instruction starvation.

## Interface
- STARVE_MAX, 4: number of consecutive data completions allowed while iREN is pending before an instruction grant is forced; legal range 1 to 15.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address (word_t).
- iwait  out  1  0 for exactly the completing cycle of an instruction grant; otherwise 1.
- iload  out  32  instruction data; equals ramload.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dominates dREN.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  0 for exactly the completing cycle of a data grant; otherwise 1.
- dload  out  32  data read value; equals ramload.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status (ramstate_t: FREE, BUSY, ACCESS, ERROR).

## Operation
- States are IDLE, IGRANT and DGRANT, held in a registered state register.
- In IDLE:
  - If dREN or dWEN is high and the forced-instruction condition (starve_cnt == STARVE_MAX and iREN) is false, go to DGRANT.
  - Otherwise, if iREN is high, go to IGRANT.
  - Otherwise, stay in IDLE.
- Output drive by state:
  - DGRANT: ramaddr = daddr, ramstore = dstore, ramWEN = dWEN, ramREN = dREN & ~dWEN.
  - IGRANT: ramaddr = iaddr, ramREN = 1, ramWEN = 0, ramstore = 0.
  - IDLE: ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
- Completion: when in a grant state with ramstate == ACCESS, the matching wait goes 0 combinationally in that cycle, and the next state is IDLE.
- FREE, BUSY and ERROR all hold the grant and keep the request asserted. An ERROR response is therefore retried indefinitely.
- Request withdrawn mid-grant: if the granted requester's enable(s) fall before ACCESS, the block returns to IDLE on the next edge. No wait is released.
- Starvation counter (4 bits, saturating):
  - On a data completion with iREN high, increment, saturating at STARVE_MAX.
  - On an instruction completion, or any cycle in IDLE with iREN low, clear to 0.
- The non-granted requester's wait is always 1.
- iload and dload are wired to ramload unconditionally. Consumers qualify them with their wait signal.

## Timing
- Reset values: state = IDLE, starve_cnt = 0, iwait = dwait = 1, ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0.
- Reset asserted mid-grant aborts the transaction immediately. No wait is released, and RAM strobes drop asynchronously.
- Minimum latency is 2 cycles. A request seen in IDLE at edge N puts the grant in place from cycle N+1. If RAM answers ACCESS in cycle N+1, the wait is 0 in cycle N+1.
- There is always one IDLE bubble between consecutive grants, so RAM strobes are low for at least one cycle between transactions.
- Simultaneous iREN and dREN/dWEN in IDLE:
  - data wins, unless starve_cnt == STARVE_MAX, in which case instruction wins.
- dREN and dWEN high together are treated as a write.
- ramstate == ACCESS while in IDLE is ignored.

## Structure
- Add arb_state_t (IDLE, IGRANT, DGRANT) to cpu_types_pkg, alongside the existing ramstate_t and word_t. Reuse both existing types for the ports.
- Build as one flat module: a state register, the starvation counter, and a combinational output/next-state block. No sub-module is warranted.
- The top level connects the block in place of the current combinational RAM glue.

## Test plan
- Reset with both requests high: while RST = 1, iwait = dwait = 1 and ramREN = ramWEN = 0. The first post-reset edge enters DGRANT.
- Instruction fetch only: iREN = 1, iaddr = 0x40, RAM gives ACCESS after 3 BUSY cycles. Expect ramaddr = 0x40 and ramREN = 1 for 4 cycles, iwait = 0 in the 4th cycle only, and IDLE next.
- Data write: dWEN = 1, daddr = 0x100, dstore = 0xDEADBEEF. Expect ramWEN = 1, ramREN = 0, ramstore = 0xDEADBEEF, and dwait = 0 exactly on the ACCESS cycle.
- Starvation, STARVE_MAX = 4, iREN held, data requests back-to-back: expect 4 data completions, then an IGRANT (iaddr driven) before the 5th data grant, and starve_cnt back to 0.
- ERROR then ACCESS: ERROR for 2 cycles, then ACCESS. Expect the grant and address held throughout, and dwait = 0 only on the ACCESS cycle.
- Abort cases:
  - RST pulsed during DGRANT: outputs return to reset values immediately, and no dwait = 0 pulse occurs.
  - dREN dropped mid-grant: back to IDLE, no dwait = 0 pulse.
